wps_receive: RTL and testbench

- Receive-side counterpart of the WPS pixel sender.
- Captures a DE-qualified video stream (h_sync/v_sync/de/pixel) and writes pixels into an external dual-bank ping-pong RAM.
- Hands each filled bank to the downstream reader with a full/release handshake.
- Skips the leading offset line of every frame and counts lines and frames.

---
 rtl/wps_receive.sv | 232 +++++++++++++++++++++++
 tb/tb_wps_receive.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wps_receive.sv
// rtl/wps_receive.sv - DE-qualified video capture into a dual-bank ping-pong line RAM
// Optional macro WPS_RX_CHECKSUM_EN adds frame_checksum / frame_checksum_valid.
module wps_receive #(
  parameter int DATA_W          = 24,
  parameter int PIX_PER_LINE    = 80,
  parameter int LINES_PER_FRAME = 1080,
  parameter int LINES_PER_BANK  = 8,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       frame_num_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] pix_data_in,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        bank_full,
  input  logic [1:0]        bank_release,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              frame_err
`ifdef WPS_RX_CHECKSUM_EN
  ,
  output logic [31:0]       frame_checksum,
  output logic              frame_checksum_valid
`endif
);

  localparam int PC_W = $clog2(PIX_PER_LINE + 1);
  localparam int LC_W = $clog2(LINES_PER_FRAME + 1);
  localparam int LB_W = $clog2(LINES_PER_BANK + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VSYNC, S_SKIP_OFFSET, S_CAPTURE, S_DONE
  } state_t;

  state_t            state_q;
  logic              hs_unused_q, vs_q, vs_qq, de_q, de_qq;
  logic [DATA_W-1:0] pix_q;
  logic              wr_en_q, wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [1:0]        bank_full_q;
  logic              busy_q, done_q, overflow_q, frame_err_q;
  logic [31:0]       frame_num_reg_q, frame_cnt_q;
  logic [LC_W-1:0]   line_cnt_q;
  logic [LB_W-1:0]   lib_q;
  logic [PC_W-1:0]   pix_cnt_q;
  logic              cur_bank_q, drop_q;

  logic              vs_rise, de_rise, de_fall, drop_now, wr_now;
  logic              line_end, early, frame_end;
  logic [PC_W-1:0]   pix_idx;
  logic [LC_W-1:0]   line_cnt_inc;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [LB_W-1:0]   lib_d;
  logic              cur_bank_d;
  logic [1:0]        set_mask, bank_full_d;

  always_comb begin
    vs_rise      = vs_q & ~vs_qq;
    de_rise      = de_q & ~de_qq;
    de_fall      = ~de_q & de_qq;
    // The drop decision is taken on the first pixel and held for the whole line
    drop_now     = de_rise ? bank_full_q[cur_bank_q] : drop_q;
    pix_idx      = de_rise ? '0 : pix_cnt_q;
    wr_now       = (state_q == S_CAPTURE) && de_q && !drop_now &&
                   (pix_idx < PC_W'(PIX_PER_LINE));
    wr_addr_d    = ADDR_W'(lib_q) * ADDR_W'(PIX_PER_LINE) + ADDR_W'(pix_idx);
    line_end     = (state_q == S_CAPTURE) && de_fall && !vs_rise;
    early        = (state_q == S_CAPTURE) && vs_rise;
    line_cnt_inc = line_cnt_q + LC_W'(1);
    frame_end    = (line_end && (line_cnt_inc == LC_W'(LINES_PER_FRAME))) || early;

    lib_d      = lib_q;
    cur_bank_d = cur_bank_q;
    set_mask   = '0;
    if (line_end && !drop_q) begin
      if (lib_q == LB_W'(LINES_PER_BANK - 1)) begin
        set_mask[cur_bank_q] = 1'b1;
        cur_bank_d           = ~cur_bank_q;
        lib_d                = '0;
      end else begin
        lib_d = lib_q + LB_W'(1);
      end
    end
    if (frame_end && (lib_d != '0)) begin
      set_mask[cur_bank_d] = 1'b1;
      cur_bank_d           = ~cur_bank_d;
      lib_d                = '0;
    end
    bank_full_d = (bank_full_q & ~bank_release) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      hs_unused_q     <= 1'b0;
      vs_q            <= 1'b0;
      vs_qq           <= 1'b0;
      de_q            <= 1'b0;
      de_qq           <= 1'b0;
      pix_q           <= '0;
      wr_en_q         <= 1'b0;
      wr_bank_q       <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      bank_full_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_num_reg_q <= '0;
      frame_cnt_q     <= '0;
      line_cnt_q      <= '0;
      lib_q           <= '0;
      pix_cnt_q       <= '0;
      cur_bank_q      <= 1'b0;
      drop_q          <= 1'b0;
    end else begin
      hs_unused_q <= h_sync_in;
      vs_q        <= v_sync_in;
      vs_qq       <= vs_q;
      de_q        <= de_in;
      de_qq       <= de_q;
      pix_q       <= pix_data_in;
      wr_en_q     <= wr_now;
      if (wr_now) begin
        wr_bank_q <= cur_bank_q;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= pix_q;
        pix_cnt_q <= pix_idx + PC_W'(1);
      end else if (de_rise) begin
        pix_cnt_q <= '0;
      end
      bank_full_q <= bank_full_d;
      lib_q       <= lib_d;
      cur_bank_q  <= cur_bank_d;
      done_q      <= 1'b0;
      if ((state_q == S_CAPTURE) && de_rise) begin
        drop_q <= bank_full_q[cur_bank_q];
        if (bank_full_q[cur_bank_q]) overflow_q <= 1'b1;
      end
      if (line_end) line_cnt_q <= line_cnt_inc;

      case (state_q)
        S_IDLE: begin
          if (start && (frame_num_in != 32'd0)) begin
            frame_num_reg_q <= frame_num_in - 32'd1;
            frame_cnt_q     <= '0;
            overflow_q      <= 1'b0;
            frame_err_q     <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= S_WAIT_VSYNC;
          end
        end
        S_WAIT_VSYNC: begin
          if (vs_rise) begin
            line_cnt_q <= '0;
            state_q    <= S_SKIP_OFFSET;
          end
        end
        S_SKIP_OFFSET: begin
          if (de_fall) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (frame_end) begin
            if (early) frame_err_q <= 1'b1;
            if (frame_cnt_q == frame_num_reg_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              frame_cnt_q <= frame_cnt_q + 32'd1;
              if (early) begin
                line_cnt_q <= '0;
                state_q    <= S_SKIP_OFFSET;
              end else begin
                state_q <= S_WAIT_VSYNC;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign bank_full = bank_full_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

`ifdef WPS_RX_CHECKSUM_EN
  logic [31:0] csum_acc_q, csum_q, pix_ext;
  logic        csum_valid_q;

  assign pix_ext = 32'(pix_q);

  // The published value includes a write issued in the same cycle as the frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_acc_q   <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_valid_q <= frame_end;
      if (frame_end) csum_q <= csum_acc_q + (wr_now ? pix_ext : 32'd0);
      if (vs_rise)     csum_acc_q <= wr_now ? pix_ext : 32'd0;
      else if (wr_now) csum_acc_q <= csum_acc_q + pix_ext;
    end
  end

  assign frame_checksum       = csum_q;
  assign frame_checksum_valid = csum_valid_q;
`endif

endmodule

// File: tb/tb_wps_receive.sv
// tb/tb_wps_receive.sv - scoreboard bench for wps_receive (small geometry: 4 pix, 4 lines, 2 lines/bank)
module tb_wps_receive;

  typedef struct packed {
    logic        bank;
    logic [9:0]  addr;
    logic [23:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start, h_sync_in, v_sync_in, de_in;
  logic [31:0] frame_num_in;
  logic [23:0] pix_data_in;
  logic        wr_en, wr_bank;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic [1:0]  bank_full, bank_release;
  logic        busy, done, overflow, frame_err;
`ifdef WPS_RX_CHECKSUM_EN
  logic [31:0] frame_checksum;
  logic        frame_checksum_valid;
  int          cs_cnt = 0;
  logic [31:0] cs_val = '0;
`endif

  int          nchecks = 0;
  int          nerr = 0;
  int          done_cnt = 0;
  logic        auto_rel = 1'b0;
  logic        mon_ignore = 1'b0;
  logic [1:0]  rel_manual = 2'b00;
  logic [1:0]  bf_prev = 2'b00;
  logic [1:0]  hist[$];
  wr_t         exp_q[$];
  wr_t         e;

  always #5 clk = ~clk;

  wps_receive #(
    .DATA_W(24), .PIX_PER_LINE(4), .LINES_PER_FRAME(4), .LINES_PER_BANK(2), .ADDR_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_num_in(frame_num_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in), .pix_data_in(pix_data_in),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .bank_full(bank_full), .bank_release(bank_release), .busy(busy), .done(done),
    .overflow(overflow), .frame_err(frame_err)
`ifdef WPS_RX_CHECKSUM_EN
    , .frame_checksum(frame_checksum), .frame_checksum_valid(frame_checksum_valid)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expw(input int b, input int a, input int d);
    exp_q.push_back({1'(b), 10'(a), 24'(d)});
  endtask

  // Monitor: scoreboard pops, bank_full history, reader model
  always @(negedge clk) begin
    if (bank_full != bf_prev) begin
      if (bank_full != 2'b00) hist.push_back(bank_full);
      bf_prev = bank_full;
    end
    if (done) done_cnt++;
`ifdef WPS_RX_CHECKSUM_EN
    if (frame_checksum_valid) begin
      cs_cnt++;
      cs_val = frame_checksum;
    end
`endif
    if (wr_en && !mon_ignore) begin
      chk("write_to_full_bank", bank_full[wr_bank], 1'b0);
      if (exp_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_write: got bank=%0d addr=%0d data=%0h, required no write",
                 wr_bank, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_bank", wr_bank, e.bank);
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
    bank_release = auto_rel ? bank_full : rel_manual;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      de_in = 1'b1;
      pix_data_in = 24'(first + i);
      @(negedge clk);
    end
    de_in = 1'b0;
    pix_data_in = '0;
    h_sync_in = 1'b1;
    idle(1);
    h_sync_in = 1'b0;
    idle(2);
  endtask

  task automatic vsync();
    v_sync_in = 1'b1;
    idle(2);
    v_sync_in = 1'b0;
    idle(3);
  endtask

  task automatic do_start(input int n);
    frame_num_in = 32'(n);
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic four_lines(input int first);
    for (int l = 0; l < 4; l++) send_line(4, first + 4 * l);
  endtask

  task automatic clear_stats();
    done_cnt = 0;
    hist.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; frame_num_in = '0; h_sync_in = 1'b0;
    v_sync_in = 1'b0; de_in = 1'b0; pix_data_in = '0;
    idle(3);
    chk("reset_outputs", {wr_en, wr_bank, wr_addr, wr_data, bank_full, busy, done, overflow, frame_err}, '0);
    rst = 1'b0;
    idle(2);
    chk("post_reset_outputs", {wr_en, wr_bank, wr_addr, wr_data, bank_full, busy, done, overflow, frame_err}, '0);

    // Basic single frame with a prompt reader
    clear_stats();
    auto_rel = 1'b1;
`ifdef WPS_RX_CHECKSUM_EN
    cs_cnt = 0;
`endif
    for (int i = 0; i < 16; i++) expw(i / 8, i % 8, i + 1);
    do_start(1);
    chk("t1_busy_after_start", busy, 1'b1);
    idle(2);
    vsync();
    send_line(1, 24'hFFFFFF);
    four_lines(1);
    wait_idle("t1_idle_timeout");
    idle(3);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_overflow", overflow, 1'b0);
    chk("t1_frame_err", frame_err, 1'b0);
    chk("t1_pending_writes", exp_q.size(), 0);
    chk("t1_hist_len", hist.size(), 2);
    chk("t1_hist0", (hist.size() > 0) ? hist[0] : 2'b00, 2'b01);
    chk("t1_hist1", (hist.size() > 1) ? hist[1] : 2'b00, 2'b10);
    chk("t1_bank_full_released", bank_full, 2'b00);
`ifdef WPS_RX_CHECKSUM_EN
    chk("t1_checksum_pulses", cs_cnt, 1);
    chk("t1_checksum", cs_val, 32'd136);
`endif

    // Reader never releases: second frame is dropped entirely
    clear_stats();
    auto_rel = 1'b0;
    for (int i = 0; i < 16; i++) expw(i / 8, i % 8, i + 1);
    do_start(2);
    idle(2);
    vsync();
    send_line(1, 24'hFFFFFF);
    four_lines(1);
    vsync();
    send_line(1, 24'hFFFFFF);
    four_lines(201);
    wait_idle("t2_idle_timeout");
    chk("t2_overflow", overflow, 1'b1);
    chk("t2_bank_full", bank_full, 2'b11);
    chk("t2_done_pulses", done_cnt, 1);
    chk("t2_frame_err", frame_err, 1'b0);
    chk("t2_pending_writes", exp_q.size(), 0);
    rel_manual = 2'b11;
    idle(1);
    rel_manual = 2'b00;
    idle(1);
    chk("t2_manual_release", bank_full, 2'b00);

    // Short and long lines; overflow cleared by the new start
    clear_stats();
    auto_rel = 1'b1;
    expw(0, 0, 1); expw(0, 1, 2);
    for (int i = 0; i < 4; i++) expw(0, 4 + i, 10 + i);
    for (int i = 0; i < 4; i++) expw(1, i, 20 + i);
    for (int i = 0; i < 4; i++) expw(1, 4 + i, 30 + i);
    do_start(1);
    chk("t3_overflow_cleared", overflow, 1'b0);
    idle(2);
    vsync();
    send_line(1, 24'hFFFFFF);
    send_line(2, 1);
    send_line(6, 10);
    send_line(4, 20);
    send_line(4, 30);
    wait_idle("t3_idle_timeout");
    chk("t3_pending_writes", exp_q.size(), 0);
    chk("t3_done_pulses", done_cnt, 1);

    // Early v_sync after three lines, then a normal second frame
    clear_stats();
    for (int i = 0; i < 8; i++) expw(0, i, i + 1);
    for (int i = 0; i < 4; i++) expw(1, i, 9 + i);
    for (int i = 0; i < 16; i++) expw(i / 8, i % 8, 101 + i);
    do_start(2);
    idle(2);
    vsync();
    send_line(1, 24'hFFFFFF);
    send_line(4, 1);
    send_line(4, 5);
    send_line(4, 9);
    vsync();
    chk("t4_frame_err", frame_err, 1'b1);
    chk("t4_busy_after_early_vsync", busy, 1'b1);
    send_line(1, 24'hFFFFFF);
    four_lines(101);
    wait_idle("t4_idle_timeout");
    chk("t4_pending_writes", exp_q.size(), 0);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_overflow", overflow, 1'b0);
    chk("t4_hist_len", hist.size(), 4);
    chk("t4_partial_bank_flushed", (hist.size() > 1) ? hist[1] : 2'b00, 2'b10);

    // start with zero frames is ignored
    do_start(0);
    idle(3);
    chk("t5_busy_zero_frames", busy, 1'b0);

    // Reset in the middle of a captured line
    mon_ignore = 1'b1;
    do_start(1);
    idle(2);
    vsync();
    send_line(1, 24'hFFFFFF);
    de_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      pix_data_in = 24'(i);
      @(negedge clk);
    end
    chk("t6_writing_before_reset", {wr_en, wr_data}, {1'b1, 24'd2});
    rst = 1'b1;
    #1;
    chk("t6_outputs_in_reset", {wr_en, wr_bank, wr_addr, wr_data, bank_full, busy, done, overflow, frame_err}, '0);
    mon_ignore = 1'b0;
    pix_data_in = 24'd4;
    @(negedge clk);
    rst = 1'b0;
    de_in = 1'b0;
    idle(3);
    send_line(4, 50);
    idle(4);
    chk("t6_busy_after_reset", busy, 1'b0);
    chk("t6_pending_writes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
